// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Scoreboard of in-flight destinations for an in-order pipeline.
//               Selects forwarding sources, stalls decode on load-use, flushes
//               on redirect. Optional macro PIPE_HAZARD_LOAD_STALL_EN enables
//               load-use stalling and the stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
  parameter int DEPTH       = 2,
  parameter int NSRC        = 2,
  parameter int RAW         = 5,
  parameter int LOAD_LAT    = 2,
  parameter int KILL_STAGES = 1,
  localparam int SELW       = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 dec_valid,
  input  logic [RAW-1:0]       dec_rd,
  input  logic                 dec_we,
  input  logic                 dec_is_load,
  input  logic [NSRC*RAW-1:0]  dec_rs,
  input  logic [NSRC-1:0]      dec_rs_used,
  input  logic                 mem_stall,
  input  logic                 redirect,
  output logic                 dec_accept,
  output logic                 stall_dec,
  output logic                 kill,
  output logic [NSRC*SELW-1:0] fwd_sel,
  output logic                 wb_we,
  output logic [RAW-1:0]       wb_rd,
  output logic [15:0]          stall_count
);

  localparam logic [SELW-1:0] c_LOAD_LAT = SELW'(LOAD_LAT);

  logic [DEPTH:1]   r_valid;
  logic [DEPTH:1]   r_we;
  logic [DEPTH:1]   r_ld;
  logic [RAW-1:0]   r_rd [1:DEPTH];
  logic             r_pend_redirect;

  logic [SELW-1:0]  w_sel [NSRC];
  logic [NSRC-1:0]  w_sel_ld;
  logic             w_ld_hit;
  logic             w_hazard;
  logic             w_flush;

  // Scan oldest to youngest so the youngest matching producer wins.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      w_sel[i]    = '0;
      w_sel_ld[i] = 1'b0;
      for (int k = DEPTH; k >= 1; k--) begin
        if (r_valid[k] && r_we[k] && (r_rd[k] != '0) &&
            (r_rd[k] == dec_rs[i*RAW +: RAW]) && dec_rs_used[i]) begin
          w_sel[i]    = SELW'(k);
          w_sel_ld[i] = r_ld[k];
        end
      end
    end
  end

  always_comb begin
    fwd_sel  = '0;
    w_ld_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      fwd_sel[i*SELW +: SELW] = w_sel[i];
      if (w_sel_ld[i] && (w_sel[i] < c_LOAD_LAT)) begin
        w_ld_hit = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_LOAD_STALL_EN
  assign w_hazard = dec_valid & w_ld_hit;
`else
  // Load delay is scheduled by software: early load data is never waited for.
  assign w_hazard = 1'b0 & w_ld_hit;
`endif

  assign stall_dec  = mem_stall | w_hazard;
  assign w_flush    = (redirect | r_pend_redirect) & ~mem_stall;
  assign kill       = w_flush;
  assign dec_accept = dec_valid & ~stall_dec & ~redirect & ~mem_stall & ~r_pend_redirect;
  assign wb_we      = r_valid[DEPTH] & r_we[DEPTH];
  assign wb_rd      = r_rd[DEPTH];

  // Flushed stages do not advance, so stage KILL_STAGES+1 receives a bubble too.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid         <= '0;
      r_we            <= '0;
      r_ld            <= '0;
      r_pend_redirect <= 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
        r_rd[k] <= '0;
      end
    end else if (!mem_stall) begin
      r_pend_redirect <= 1'b0;
      r_valid[1]      <= dec_accept;
      r_rd[1]         <= dec_rd;
      r_we[1]         <= dec_we;
      r_ld[1]         <= dec_is_load;
      for (int k = 2; k <= DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1] & ~(w_flush && (k <= KILL_STAGES + 1));
        r_rd[k]    <= r_rd[k-1];
        r_we[k]    <= r_we[k-1];
        r_ld[k]    <= r_ld[k-1];
      end
    end else if (redirect) begin
      r_pend_redirect <= 1'b1;
    end
  end

`ifdef PIPE_HAZARD_LOAD_STALL_EN
  logic [15:0] r_stall_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_count <= '0;
    end else if (w_hazard && !mem_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// Testbench for pipe_hazard_unit: directed sequences with literal expectations,
// then random traffic checked every cycle against a stage-array model.
module tb_pipe_hazard_unit;

  localparam int DEPTH    = 2;
  localparam int NSRC     = 2;
  localparam int RAW      = 5;
  localparam int LOAD_LAT = 2;
  localparam int KILL     = 1;
  localparam int SELW     = $clog2(DEPTH + 1);
`ifdef PIPE_HAZARD_LOAD_STALL_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 dec_valid;
  logic [RAW-1:0]       dec_rd;
  logic                 dec_we;
  logic                 dec_is_load;
  logic [NSRC*RAW-1:0]  dec_rs;
  logic [NSRC-1:0]      dec_rs_used;
  logic                 mem_stall;
  logic                 redirect;
  logic                 dec_accept;
  logic                 stall_dec;
  logic                 kill;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 wb_we;
  logic [RAW-1:0]       wb_rd;
  logic [15:0]          stall_count;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_unit #(
    .DEPTH(DEPTH), .NSRC(NSRC), .RAW(RAW), .LOAD_LAT(LOAD_LAT), .KILL_STAGES(KILL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .dec_valid(dec_valid), .dec_rd(dec_rd),
    .dec_we(dec_we), .dec_is_load(dec_is_load), .dec_rs(dec_rs),
    .dec_rs_used(dec_rs_used), .mem_stall(mem_stall), .redirect(redirect),
    .dec_accept(dec_accept), .stall_dec(stall_dec), .kill(kill),
    .fwd_sel(fwd_sel), .wb_we(wb_we), .wb_rd(wb_rd), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic           v;
    logic [RAW-1:0] rd;
    logic           we;
    logic           ld;
  } ent_t;

  ent_t m [1:DEPTH];
  bit   m_pend;
  int   m_cnt;
  bit   u_haz, u_acc, u_fl;

  // Youngest in-flight writer of the source register, 0 if none.
  function automatic int exp_fwd(int i);
    logic [RAW-1:0] rs;
    rs = dec_rs[i*RAW +: RAW];
    if (!dec_rs_used[i] || rs == '0) return 0;
    for (int k = 1; k <= DEPTH; k++)
      if (m[k].v && m[k].we && m[k].rd == rs) return k;
    return 0;
  endfunction

  function automatic bit exp_hazard();
    int k;
    if (!HAZ || !dec_valid) return 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      k = exp_fwd(i);
      if (k != 0 && m[k].ld && k < LOAD_LAT) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_stall();
    return mem_stall || exp_hazard();
  endfunction

  function automatic bit exp_accept();
    return dec_valid && !exp_stall() && !redirect && !mem_stall && !m_pend;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 1; k <= DEPTH; k++) m[k] = '0;
      m_pend = 1'b0;
      m_cnt  = 0;
    end else begin
      u_haz = exp_hazard();
      u_acc = exp_accept();
      u_fl  = (redirect || m_pend) && !mem_stall;
      if (!mem_stall) begin
        for (int k = DEPTH; k >= 2; k--) begin
          m[k] = m[k-1];
          if (u_fl && k <= KILL + 1) m[k].v = 1'b0;
        end
        m[1]   = {u_acc, dec_rd, dec_we, dec_is_load};
        m_pend = 1'b0;
        if (u_haz && m_cnt < 65535) m_cnt++;
      end else if (redirect) begin
        m_pend = 1'b1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the active edge.
  logic [NSRC*SELW-1:0] e_fwd;
  always @(negedge clk) begin
    for (int i = 0; i < NSRC; i++) e_fwd[i*SELW +: SELW] = SELW'(exp_fwd(i));
    chk("m_accept", {31'b0, dec_accept}, {31'b0, exp_accept()});
    chk("m_stall",  {31'b0, stall_dec},  {31'b0, exp_stall()});
    chk("m_kill",   {31'b0, kill},       {31'b0, (redirect || m_pend) && !mem_stall});
    chk("m_fwd",    32'(fwd_sel),        32'(e_fwd));
    chk("m_wbwe",   {31'b0, wb_we},      {31'b0, m[DEPTH].v && m[DEPTH].we});
    if (m[DEPTH].v && m[DEPTH].we) chk("m_wbrd", 32'(wb_rd), 32'(m[DEPTH].rd));
    chk("m_cnt",    32'(stall_count),    32'(m_cnt));
  end

  // ---------------- stimulus ----------------
  function automatic logic [SELW-1:0] fs(int i);
    return fwd_sel[i*SELW +: SELW];
  endfunction

  task automatic set_in(logic v, logic [RAW-1:0] rd, logic we, logic ld,
                        logic [RAW-1:0] rs0, logic [RAW-1:0] rs1, logic [1:0] used);
    dec_valid   = v;
    dec_rd      = rd;
    dec_we      = we;
    dec_is_load = ld;
    dec_rs      = {rs1, rs0};
    dec_rs_used = used;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_stall = 1'b0;
    redirect  = 1'b0;
    set_in(1, 5'd3, 1, 0, 5'd3, 5'd4, 2'b11);
    #3;
    chk("rst_accept", {31'b0, dec_accept}, 32'd1);
    chk("rst_stall",  {31'b0, stall_dec},  32'd0);
    chk("rst_kill",   {31'b0, kill},       32'd0);
    chk("rst_fwd",    32'(fwd_sel),        32'd0);
    chk("rst_wbwe",   {31'b0, wb_we},      32'd0);
    chk("rst_wbrd",   32'(wb_rd),          32'd0);
    chk("rst_cnt",    32'(stall_count),    32'd0);
    tick(); tick();
    reset_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 2'b00);
    tick();

    // addi x5 ; add x6,x5,x1 ; reader of x5
    set_in(1, 5'd5, 1, 0, 5'd0, 5'd0, 2'b00); tick();
    set_in(1, 5'd6, 1, 0, 5'd5, 5'd1, 2'b11); look();
    chk("alu_fwd0_s1", 32'(fs(0)), 32'd1);
    chk("alu_fwd1_rf", 32'(fs(1)), 32'd0);
    chk("alu_nostall", {31'b0, stall_dec}, 32'd0);
    tick();
    set_in(1, 5'd9, 1, 0, 5'd5, 5'd0, 2'b01); look();
    chk("alu_fwd0_s2", 32'(fs(0)), 32'd2);
    tick();

    // lw x7 ; add x8,x7,x7
    set_in(1, 5'd7, 1, 1, 5'd0, 5'd0, 2'b00); tick();
    set_in(1, 5'd8, 1, 0, 5'd7, 5'd7, 2'b11); look();
    chk("ld_stall",   {31'b0, stall_dec},  {31'b0, HAZ});
    chk("ld_accept",  {31'b0, dec_accept}, {31'b0, !HAZ});
    chk("ld_fwd0_s1", 32'(fs(0)), 32'd1);
    chk("ld_fwd1_s1", 32'(fs(1)), 32'd1);
`ifdef PIPE_HAZARD_LOAD_STALL_EN
    tick(); look();
    chk("ld_unstall", {31'b0, stall_dec},  32'd0);
    chk("ld_fwd0_s2", 32'(fs(0)), 32'd2);
    chk("ld_fwd1_s2", 32'(fs(1)), 32'd2);
    chk("ld_acc2",    {31'b0, dec_accept}, 32'd1);
    chk("ld_cnt",     32'(stall_count),    32'd1);
`else
    chk("ld_cnt0",    32'(stall_count),    32'd0);
`endif
    tick();

    // redirect kills stage 1
    set_in(1, 5'd10, 1, 0, 5'd0, 5'd0, 2'b00); tick();
    set_in(1, 5'd11, 1, 0, 5'd0, 5'd0, 2'b00);
    redirect = 1'b1; look();
    chk("rd_kill",   {31'b0, kill},       32'd1);
    chk("rd_noacc",  {31'b0, dec_accept}, 32'd0);
    tick();
    redirect = 1'b0;
    set_in(1, 5'd12, 0, 0, 5'd10, 5'd11, 2'b11); look();
    chk("rd_kill_off", {31'b0, kill},  32'd0);
    chk("rd_fwd_gone", 32'(fwd_sel),   32'd0);
    chk("rd_wb0",      {31'b0, wb_we}, 32'd0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 2'b00); look();
    chk("rd_wb1",      {31'b0, wb_we}, 32'd0);
    tick();

    // redirect held pending across a 3-cycle memory stall
    set_in(1, 5'd12, 1, 0, 5'd0, 5'd0, 2'b00); tick();
    set_in(1, 5'd13, 0, 0, 5'd12, 5'd0, 2'b01);
    mem_stall = 1'b1;
    redirect  = 1'b1; look();
    chk("ps_kill0",  {31'b0, kill},       32'd0);
    chk("ps_stall",  {31'b0, stall_dec},  32'd1);
    chk("ps_noacc",  {31'b0, dec_accept}, 32'd0);
    tick();
    redirect = 1'b0;
    for (int c = 0; c < 2; c++) begin
      look();
      chk("ps_kill_hold", {31'b0, kill}, 32'd0);
      chk("ps_fwd_hold",  32'(fs(0)),    32'd1);
      tick();
    end
    mem_stall = 1'b0; look();
    chk("ps_kill1",  {31'b0, kill},       32'd1);
    chk("ps_noacc1", {31'b0, dec_accept}, 32'd0);
    tick(); look();
    chk("ps_kill2",  {31'b0, kill},       32'd0);
    chk("ps_flushed", 32'(fs(0)),         32'd0);
    chk("ps_acc",    {31'b0, dec_accept}, 32'd1);
    chk("ps_wb",     {31'b0, wb_we},      32'd0);
    tick();

    // reset mid-stream with two writers in flight
    set_in(1, 5'd13, 1, 0, 5'd0, 5'd0, 2'b00); tick();
    set_in(1, 5'd14, 1, 0, 5'd0, 5'd0, 2'b00); tick();
    set_in(1, 5'd15, 0, 0, 5'd14, 5'd13, 2'b11); look();
    chk("mr_wbwe",  {31'b0, wb_we}, 32'd1);
    chk("mr_wbrd",  32'(wb_rd),     32'd13);
    reset_n = 1'b0; #1;
    chk("mr_wb_imm",  {31'b0, wb_we},      32'd0);
    chk("mr_fwd",     32'(fwd_sel),        32'd0);
    chk("mr_acc",     {31'b0, dec_accept}, 32'd1);
    chk("mr_cnt",     32'(stall_count),    32'd0);
    tick();
    reset_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 2'b00);
    for (int c = 0; c < 2; c++) begin
      look();
      chk("mr_nocommit", {31'b0, wb_we}, 32'd0);
      tick();
    end
    set_in(1, 5'd0, 1, 0, 5'd0, 5'd0, 2'b11); tick();
    set_in(1, 5'd1, 1, 0, 5'd0, 5'd0, 2'b11); look();
    chk("x0_fwd", 32'(fwd_sel), 32'd0);
    tick();

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) reset_n = 1'b0;
      else reset_n = 1'b1;
      mem_stall = ($urandom_range(0, 99) < 15);
      redirect  = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 99) < 80)
        set_in(1, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 99) < 35), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
      else
        set_in(0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 2'b00);
      tick();
    end
    reset_n   = 1'b1;
    mem_stall = 1'b0;
    redirect  = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 2'b00);
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_unit.md
PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DEPTH, 2: tracked stages after decode (1..DEPTH, DEPTH = writeback); range 2..6.
- NSRC, 2: source operands per instruction; range 1..3.
- RAW, 5: register address width.
- LOAD_LAT, 2: first stage index at which load data is forwardable; range 1..DEPTH.
- KILL_STAGES, 1: stages invalidated on redirect; range 1..DEPTH-1.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: sole clock, rising edge.
- reset_n, in, 1: asynchronous, active-low reset.
- dec_valid, in, 1: instruction present at decode.
- dec_rd, in, RAW: destination register.
- dec_we, in, 1: writes rd.
- dec_is_load, in, 1: instruction is a load.
- dec_rs, in, NSRC*RAW: source addresses; src i at bits [i*RAW +: RAW].
- dec_rs_used, in, NSRC: source i is read.
- mem_stall, in, 1: freeze the whole pipeline.
- redirect, in, 1: taken branch or jump resolved.
- dec_accept, out, 1: decode instruction enters stage 1 at this edge.
- stall_dec, out, 1: decode must hold.
- kill, out, 1: stages 1..KILL_STAGES are being flushed.
- fwd_sel, out, NSRC*SELW with SELW=$clog2(DEPTH+1): 0 = register file, k = forward from stage k.
- wb_we, out, 1: stage DEPTH commit write enable.
- wb_rd, out, RAW: stage DEPTH destination.
- stall_count, out, 16: saturating count of cycles with a hazard stall.

Function
REQ-003 SHALL keep one entry per stage: valid, rd, we, ld.
REQ-004 SHALL, on every edge with mem_stall=0, shift entry k-1 into k; stage 1 SHALL load the decode fields when dec_accept=1, else a bubble (valid=0).
REQ-005 SHALL hold all entries unchanged on edges with mem_stall=1.
REQ-006 SHALL drive dec_accept = dec_valid & ~stall_dec & ~redirect & ~mem_stall & ~pend_redirect.
REQ-007 SHALL treat an entry as a match for source i when valid & we & rd!=0 & rd==rs_i & dec_rs_used[i].
REQ-008 SHALL set fwd_sel[i] to the smallest matching k (youngest producer), else 0, combinationally.
REQ-009 SHALL force fwd_sel[i]=0 when rs_i==0.
REQ-010 SHALL flag a load-use hazard when the selected match for any used source has ld=1 and k<LOAD_LAT.
REQ-011 SHALL drive stall_dec = mem_stall | hazard; a hazard SHALL insert bubbles until the load reaches stage LOAD_LAT (LOAD_LAT-k cycles).
REQ-012 SHALL, on redirect with mem_stall=0, clear valid in stages 1..KILL_STAGES at the next edge (instead of shifting them), block acceptance, and drive kill=1 for that cycle.
REQ-013 SHALL, on redirect during mem_stall=1, set pend_redirect; the flush SHALL occur on the first edge with mem_stall=0; kill SHALL be asserted that cycle; pend_redirect SHALL then clear.
REQ-014 SHALL, when a hazard and redirect coincide, give redirect priority, so the stalled instruction is killed.
REQ-015 SHALL drive wb_we = valid & we of stage DEPTH, and wb_rd = rd of stage DEPTH, regardless of mem_stall.
REQ-016 SHALL increment stall_count on each edge where hazard=1 and mem_stall=0, saturating at 16'hFFFF.

Reset
REQ-017 SHALL, while reset_n=0, immediately clear all valid bits, pend_redirect and stall_count.
- Resulting outputs: dec_accept follows dec_valid, stall_dec=mem_stall, kill=0 unless redirect, fwd_sel=0, wb_we=0, wb_rd=0.
REQ-018 SHALL, on reset deasserting mid-operation, restart with an empty pipeline; no pre-reset instruction SHALL commit.

Configuration
REQ-019 SHALL support macro PIPE_HAZARD_LOAD_STALL_EN:
- Defined: REQ-010/011/016 apply.
- Undefined: hazard is tied to 0, stall_count reads 0, and loads forward from any matching stage (software-scheduled load delay); all other behaviour is unchanged.

Verification
REQ-020 Bench SHALL cover (defaults, macro defined unless stated):
- addi x5 then add x6,x5,x1 back-to-back -> fwd_sel[0]=1, stall_dec=0; one cycle later -> fwd_sel[0]=2.
- lw x7 then add x8,x7,x7 -> stall_dec=1 for 1 cycle, stall_count=1; then fwd_sel[0]=fwd_sel[1]=2, dec_accept=1.
- Same sequence with macro undefined -> no stall; fwd_sel=1 immediately.
- redirect with valid stage 1 -> next cycle stage 1 valid=0, kill=1 for 1 cycle, killed instruction never produces wb_we.
- redirect while mem_stall=1 for 3 cycles -> no flush during the stall; flush with kill=1 on the first unstalled edge.
- reset_n low mid-stream with 2 valid writers -> wb_we=0 immediately; no commits after release; add x0,x0,x0 writer -> fwd_sel stays 0.
